// File: rtl/fdam_wr_req_rr_scheduler_4.sv
// Four-requester write-request scheduler: per-requester input FIFOs, round-robin grant, output FIFO.
// Defining WR_REQ_BURST_LOCK_EN holds the grant on one requester for up to BURST_LEN consecutive words.
module fdam_wr_req_rr_scheduler_4 #(
    parameter int DATA_WIDTH             = 32,
    parameter int INPUT_FIFO_DEPTH_BITS  = 4,
    parameter int OUTPUT_FIFO_DEPTH_BITS = 4,
    parameter int BURST_LEN              = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_wr_en_in,
    input  logic [4*DATA_WIDTH-1:0] req_wr_data_in,
    output logic [3:0]              req_wr_available_in,
    input  logic                    req_wr_available_out,
    output logic                    req_wr_en_out,
    output logic [DATA_WIDTH-1:0]   req_wr_data_out,
    output logic [3:0]              overflow_err
);
    localparam int IB = INPUT_FIFO_DEPTH_BITS;
    localparam int OB = OUTPUT_FIFO_DEPTH_BITS;
    localparam logic [IB:0] I_FULL  = {1'b1, {IB{1'b0}}};
    localparam logic [IB:0] I_AVAIL = I_FULL - (IB+1)'(2);
    localparam logic [OB:0] O_FULL  = {1'b1, {OB{1'b0}}};

    logic [DATA_WIDTH-1:0] r_imem [4][1<<IB];
    logic [IB-1:0]         r_iwp  [4];
    logic [IB-1:0]         r_irp  [4];
    logic [IB:0]           r_icnt [4];
    logic [DATA_WIDTH-1:0] r_omem [1<<OB];
    logic [OB-1:0]         r_owp, r_orp;
    logic [OB:0]           r_ocnt;
    logic [1:0]            r_ptr;
    logic [3:0]            r_avail, r_ovf;
    logic                  r_en_out;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [3:0]            w_ipush, w_ipop, w_inempty;
    logic [IB:0]           w_icnt_nxt [4];
    logic                  w_opop, w_oroom, w_rr_vld, w_cand_vld, w_gnt;
    logic [1:0]            w_rr_idx, w_gidx;
    logic [DATA_WIDTH-1:0] w_gdata;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_inempty[i] = (r_icnt[i] != '0);
            w_ipush[i]   = req_wr_en_in[i] && (r_icnt[i] != I_FULL);
        end
    end

    // Scan from ptr+4 (the last winner) down to ptr+1 so the nearest successor wins.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (w_inempty[r_ptr + k[1:0]]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = r_ptr + k[1:0];
            end
        end
    end

    assign w_opop  = (r_ocnt != '0) && req_wr_available_out;
    assign w_oroom = (r_ocnt != O_FULL) || w_opop;

`ifdef WR_REQ_BURST_LOCK_EN
    localparam int BCW = $clog2(BURST_LEN + 1);
    typedef enum logic {S_IDLE, S_LOCK} state_t;
    state_t         r_state;
    logic [1:0]     r_lidx;
    logic [BCW-1:0] r_bcnt;
    logic           w_hold;

    assign w_hold     = (r_state == S_LOCK) && w_inempty[r_lidx] && (r_bcnt < BCW'(BURST_LEN));
    assign w_cand_vld = w_hold || w_rr_vld;
    assign w_gidx     = w_hold ? r_lidx : w_rr_idx;

    // A full output FIFO stalls a held burst without ending it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lidx  <= 2'd0;
            r_bcnt  <= '0;
        end else if (w_gnt) begin
            r_state <= S_LOCK;
            if (w_hold) begin
                r_bcnt <= r_bcnt + BCW'(1);
            end else begin
                r_lidx <= w_gidx;
                r_bcnt <= BCW'(1);
            end
        end else if (!w_hold) begin
            r_state <= S_IDLE;
        end
    end
`else
    assign w_cand_vld = w_rr_vld;
    assign w_gidx     = w_rr_idx;
`endif

    assign w_gnt   = w_cand_vld && w_oroom;
    assign w_gdata = r_imem[w_gidx][r_irp[w_gidx]];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_ipop[i]     = w_gnt && (w_gidx == 2'(i));
            w_icnt_nxt[i] = r_icnt[i] + (IB+1)'(w_ipush[i]) - (IB+1)'(w_ipop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ipush[i]) r_imem[i][r_iwp[i]] <= req_wr_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (w_gnt) r_omem[r_owp] <= w_gdata;
    end

    // Availability is derived from the next count so it is already low when the FIFO is one slot from full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_iwp[i]  <= '0;
                r_irp[i]  <= '0;
                r_icnt[i] <= '0;
            end
            r_owp    <= '0;
            r_orp    <= '0;
            r_ocnt   <= '0;
            r_ptr    <= 2'd3;
            r_avail  <= '0;
            r_ovf    <= '0;
            r_en_out <= 1'b0;
            r_dout   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_ipush[i]) r_iwp[i] <= r_iwp[i] + IB'(1);
                if (w_ipop[i])  r_irp[i] <= r_irp[i] + IB'(1);
                r_icnt[i]  <= w_icnt_nxt[i];
                r_avail[i] <= (w_icnt_nxt[i] <= I_AVAIL);
                r_ovf[i]   <= r_ovf[i] | (req_wr_en_in[i] && !w_ipush[i]);
            end
            if (w_gnt) begin
                r_owp <= r_owp + OB'(1);
                r_ptr <= w_gidx;
            end
            if (w_opop) begin
                r_orp  <= r_orp + OB'(1);
                r_dout <= r_omem[r_orp];
            end
            r_en_out <= w_opop;
            r_ocnt   <= r_ocnt + (OB+1)'(w_gnt) - (OB+1)'(w_opop);
        end
    end

    assign req_wr_available_in = r_avail;
    assign overflow_err        = r_ovf;
    assign req_wr_en_out       = r_en_out;
    assign req_wr_data_out     = r_dout;
endmodule

// File: tb/tb_fdam_wr_req_rr_scheduler_4.sv
// Scoreboard bench for fdam_wr_req_rr_scheduler_4: expected words queued at drive time, popped on output.
module tb_fdam_wr_req_rr_scheduler_4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_wr_en_in;
    logic [4*DW-1:0]   req_wr_data_in;
    logic [3:0]        req_wr_available_in;
    logic              req_wr_available_out;
    logic              req_wr_en_out;
    logic [DW-1:0]     req_wr_data_out;
    logic [3:0]        overflow_err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fdam_wr_req_rr_scheduler_4 dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_wr_en_in         (req_wr_en_in),
        .req_wr_data_in       (req_wr_data_in),
        .req_wr_available_in  (req_wr_available_in),
        .req_wr_available_out (req_wr_available_out),
        .req_wr_en_out        (req_wr_en_out),
        .req_wr_data_out      (req_wr_data_out),
        .overflow_err         (overflow_err)
    );

    function automatic logic [DW-1:0] word(int req, int seq);
        return {8'hC0, 4'(req), 4'h0, 16'(seq)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_wr_en_in = '0;
        req_wr_data_in = '0;
        req_wr_available_out = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_wr_en_in = '0;
        req_wr_data_in = '0;
        req_wr_available_out = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({req_wr_en_out, req_wr_data_out, req_wr_available_in, overflow_err} !== '0) begin
                bad++;
                $display("FAIL reset_outputs en=%b data=%h avail=%b ovf=%b required all zero",
                         req_wr_en_out, req_wr_data_out, req_wr_available_in, overflow_err);
            end
            req_wr_en_in = 4'($urandom);
            req_wr_data_in = {$urandom, $urandom, $urandom, $urandom};
            req_wr_available_out = 1'($urandom);
        end
        @(negedge clk);
        req_wr_en_in = '0;
        req_wr_available_out = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (req_wr_available_in !== 4'b0000) begin
            bad++;
            $display("FAIL avail_at_release got=%b exp=0000", req_wr_available_in);
        end
        @(negedge clk);
        total++;
        if (req_wr_available_in !== 4'b1111) begin
            bad++;
            $display("FAIL avail_after_release got=%b exp=1111", req_wr_available_in);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        do_reset();
        req_wr_en_in = 4'b0001;
        req_wr_data_in = '0;
        req_wr_data_in[DW-1:0] = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        @(negedge clk);
        req_wr_en_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (req_wr_en_out !== 1'(c == 2)) begin
                bad++;
                $display("FAIL single_latency edge+%0d en_out got=%b exp=%b", c, req_wr_en_out, c == 2);
            end
            if (req_wr_en_out === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (req_wr_data_out !== e) begin
                    bad++;
                    $display("FAIL single_data got=%h exp=%h", req_wr_data_out, e);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_missing got=0 words exp=1");
            exp_q.delete();
        end
    endtask

    task automatic test_fairness();
        logic [DW-1:0] e;
        int first_c, last_c, nout;
        do_reset();
`ifdef WR_REQ_BURST_LOCK_EN
        for (int blk = 0; blk < 2; blk++)
            for (int i = 0; i < 4; i++)
                for (int b = 0; b < 4; b++) exp_q.push_back(word(i, blk * 4 + b));
`else
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 4; i++) exp_q.push_back(word(i, r));
`endif
        first_c = -1;
        last_c = -1;
        nout = 0;
        for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
            if (c < 8) begin
                req_wr_en_in = 4'hF;
                for (int i = 0; i < 4; i++) req_wr_data_in[i*DW +: DW] = word(i, c);
            end else begin
                req_wr_en_in = '0;
            end
            @(negedge clk);
            if (req_wr_en_out === 1'b1) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                nout++;
                e = exp_q.pop_front();
                total++;
                if (req_wr_data_out !== e) begin
                    bad++;
                    $display("FAIL fair_order word%0d got=%h exp=%h", nout - 1, req_wr_data_out, e);
                end
            end
        end
        req_wr_en_in = '0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL fair_count got=%0d exp=32", nout);
            exp_q.delete();
        end
        total++;
        if (last_c - first_c != 31) begin
            bad++;
            $display("FAIL fair_throughput span got=%0d exp=31", last_c - first_c);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (req_wr_en_out !== 1'b0) begin
                bad++;
                $display("FAIL fair_extra got en_out=%b data=%h exp en_out=0", req_wr_en_out, req_wr_data_out);
            end
        end
        total++;
        if (overflow_err !== 4'b0000) begin
            bad++;
            $display("FAIL fair_overflow got=%b exp=0000", overflow_err);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        int pushed, seen;
        do_reset();
        req_wr_available_out = 1'b0;
        pushed = 0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (req_wr_available_in[0]) begin
                req_wr_en_in = 4'b0001;
                req_wr_data_in[DW-1:0] = word(0, pushed);
                exp_q.push_back(word(0, pushed));
                pushed++;
            end else begin
                req_wr_en_in = '0;
            end
            @(negedge clk);
            if (req_wr_en_out === 1'b1) seen++;
        end
        req_wr_en_in = '0;
        total++;
        if (pushed != 31) begin
            bad++;
            $display("FAIL bp_accepted got=%0d exp=31", pushed);
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL bp_leak got=%0d outputs exp=0", seen);
        end
        total++;
        if (req_wr_available_in[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_avail0 got=%b exp=0", req_wr_available_in[0]);
        end
        req_wr_available_out = 1'b1;
        for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (req_wr_en_out === 1'b1) begin
                e = exp_q.pop_front();
                total++;
                if (req_wr_data_out !== e) begin
                    bad++;
                    $display("FAIL bp_order got=%h exp=%h", req_wr_data_out, e);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_drain got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (overflow_err !== 4'b0000) begin
            bad++;
            $display("FAIL bp_overflow got=%b exp=0000", overflow_err);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] e;
        int extra;
        do_reset();
        req_wr_available_out = 1'b0;
        for (int k = 0; k < 16; k++) begin
            req_wr_en_in = 4'b0001;
            req_wr_data_in[DW-1:0] = word(0, k);
            exp_q.push_back(word(0, k));
            @(negedge clk);
        end
        req_wr_en_in = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            req_wr_en_in = 4'b0001;
            req_wr_data_in[DW-1:0] = word(0, 16 + k);
            if (k < 16) exp_q.push_back(word(0, 16 + k));
            @(negedge clk);
        end
        req_wr_en_in = '0;
        total++;
        if (overflow_err !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_flag got=%b exp=0001", overflow_err);
        end
        req_wr_available_out = 1'b1;
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_wr_en_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (req_wr_data_out !== e) begin
                        bad++;
                        $display("FAIL ovf_order got=%h exp=%h", req_wr_data_out, e);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0 || extra != 0) begin
            bad++;
            $display("FAIL ovf_count got missing=%0d extra=%0d exp 0/0", exp_q.size(), extra);
            exp_q.delete();
        end
        total++;
        if (overflow_err !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_sticky got=%b exp=0001", overflow_err);
        end
    endtask

    task automatic test_async_reset();
        int stale;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_wr_en_in = 4'hF;
            for (int i = 0; i < 4; i++) req_wr_data_in[i*DW +: DW] = word(i, 100 + c);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        total++;
        if (req_wr_en_out !== 1'b1) begin
            bad++;
            $display("FAIL arst_streaming got=%b exp=1", req_wr_en_out);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({req_wr_en_out, req_wr_available_in, overflow_err} !== '0) begin
            bad++;
            $display("FAIL arst_immediate en=%b avail=%b ovf=%b exp all 0",
                     req_wr_en_out, req_wr_available_in, overflow_err);
        end
        req_wr_en_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stale = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_wr_en_out === 1'b1) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL arst_stale got=%0d words exp=0", stale);
        end
        total++;
        if (req_wr_available_in !== 4'b1111) begin
            bad++;
            $display("FAIL arst_avail got=%b exp=1111", req_wr_available_in);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
